// File: rtl/bsg_demux2_gatestack_fifo_pkg.sv
// rtl/bsg_demux2_gatestack_fifo_pkg.sv - shared helpers for the gatestack demux
// Pointer sizing only; every width still derives from the instance parameters.
package bsg_demux2_gatestack_fifo_pkg;

  // Matches BSG_SAFE_CLOG2: never returns 0, so a pointer field is at least 1 bit.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_demux2_out_fifo.sv
// rtl/bsg_demux2_out_fifo.sv - per-channel valid/yumi FIFO
// Wrap-bit pointers distinguish full from empty; head is registered (no bypass).
module bsg_demux2_out_fifo
  import bsg_demux2_gatestack_fifo_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 v_i,
  input  logic [2*width_p-1:0] data_i,
  output logic                 full_o,
  output logic                 v_o,
  output logic [2*width_p-1:0] data_o,
  input  logic                 yumi_i
);

  localparam int ptr_w_lp = safe_clog2(els_p);
  localparam logic [ptr_w_lp:0] one_lp = 1;

  logic [ptr_w_lp:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2*width_p-1:0] mem_q [els_p];
  logic                 empty, enq, deq;

  assign empty  = (wptr_q == rptr_q);
  assign full_o = (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0])
                & (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp]);

  // A yumi on an empty FIFO is dropped so the pointers cannot cross.
  assign enq = v_i & ~full_o & ~reset_i;
  assign deq = yumi_i & ~empty & ~reset_i;

  assign wptr_d = enq ? (wptr_q + one_lp) : wptr_q;
  assign rptr_d = deq ? (rptr_q + one_lp) : rptr_q;

  assign v_o    = ~empty & ~reset_i;
  assign data_o = v_o ? mem_q[rptr_q[ptr_w_lp-1:0]] : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (enq) mem_q[wptr_q[ptr_w_lp-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && empty)) else $warning("yumi_i asserted while channel FIFO is empty");
    end
  end

endmodule

// File: rtl/bsg_demux2_gatestack_fifo.sv
// rtl/bsg_demux2_gatestack_fifo.sv - per-bit 2:1 demux into two buffered channels
// sel_i bit 1 routes the data bit to channel 1, bit 0 to channel 0.
module bsg_demux2_gatestack_fifo
  import bsg_demux2_gatestack_fifo_pkg::*;
#(
  parameter int width_p      = 32,
  parameter int els_p        = 2,
  parameter int drop_empty_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic [width_p-1:0] sel_i,
  output logic               ready_o,
  output logic               v0_o,
  output logic [width_p-1:0] data0_o,
  output logic [width_p-1:0] mask0_o,
  input  logic               yumi0_i,
  output logic               v1_o,
  output logic [width_p-1:0] data1_o,
  output logic [width_p-1:0] mask1_o,
  input  logic               yumi1_i
);

  logic                 full0, full1, push0, push1, keep_empty;
  logic [width_p-1:0]   mask0, mask1;
  logic [2*width_p-1:0] head0, head1;

  assign mask0 = ~sel_i;
  assign mask1 = sel_i;

  // Depends only on FIFO state and reset, never on this cycle's handshake inputs.
  assign ready_o = ~reset_i & ~full0 & ~full1;

  assign keep_empty = (drop_empty_p == 0);
  assign push0      = v_i & ready_o & (keep_empty | (|mask0));
  assign push1      = v_i & ready_o & (keep_empty | (|mask1));

  bsg_demux2_out_fifo #(.width_p(width_p), .els_p(els_p)) fifo0 (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (push0),
    .data_i ({mask0, data_i & mask0}),
    .full_o (full0),
    .v_o    (v0_o),
    .data_o (head0),
    .yumi_i (yumi0_i)
  );

  bsg_demux2_out_fifo #(.width_p(width_p), .els_p(els_p)) fifo1 (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (push1),
    .data_i ({mask1, data_i & mask1}),
    .full_o (full1),
    .v_o    (v1_o),
    .data_o (head1),
    .yumi_i (yumi1_i)
  );

  assign mask0_o = head0[2*width_p-1:width_p];
  assign data0_o = head0[width_p-1:0];
  assign mask1_o = head1[2*width_p-1:width_p];
  assign data1_o = head1[width_p-1:0];

endmodule

// File: tb/tb_bsg_demux2_gatestack_fifo.sv
// tb/tb_bsg_demux2_gatestack_fifo.sv - self-checking bench with queue-based channel model
module tb_bsg_demux2_gatestack_fifo;

  localparam int W   = 32;
  localparam int ELS = 2;

  logic         clk = 1'b0;
  logic         reset_i, v_i;
  logic [W-1:0] data_i, sel_i;
  logic         ready_o, v0_o, v1_o, yumi0_i, yumi1_i;
  logic [W-1:0] data0_o, mask0_o, data1_o, mask1_o;
  logic         nd_ready, nd_v0, nd_v1;
  logic         nd_yumi0 = 1'b0;
  logic         nd_yumi1 = 1'b0;
  logic [W-1:0] nd_data0, nd_mask0, nd_data1, nd_mask1;

  always #5 clk = ~clk;

  bsg_demux2_gatestack_fifo #(.width_p(W), .els_p(ELS), .drop_empty_p(1)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .sel_i(sel_i),
    .ready_o(ready_o),
    .v0_o(v0_o), .data0_o(data0_o), .mask0_o(mask0_o), .yumi0_i(yumi0_i),
    .v1_o(v1_o), .data1_o(data1_o), .mask1_o(mask1_o), .yumi1_i(yumi1_i)
  );

  bsg_demux2_gatestack_fifo #(.width_p(W), .els_p(ELS), .drop_empty_p(0)) dut_nd (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .sel_i(sel_i),
    .ready_o(nd_ready),
    .v0_o(nd_v0), .data0_o(nd_data0), .mask0_o(nd_mask0), .yumi0_i(nd_yumi0),
    .v1_o(nd_v1), .data1_o(nd_data1), .mask1_o(nd_mask1), .yumi1_i(nd_yumi1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] q0[$];
  logic [2*W-1:0] q1[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Channel model: each accepted word is split into an owned mask per channel.
  task automatic model_edge();
    bit rdy, pop0, pop1, push0, push1;
    if (reset_i) begin
      q0.delete();
      q1.delete();
      return;
    end
    rdy   = (q0.size() < ELS) && (q1.size() < ELS);
    pop0  = yumi0_i && (q0.size() > 0);
    pop1  = yumi1_i && (q1.size() > 0);
    push0 = v_i && rdy && (~sel_i != '0);
    push1 = v_i && rdy && (sel_i != '0);
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (push0) q0.push_back({~sel_i, data_i & ~sel_i});
    if (push1) q1.push_back({sel_i, data_i & sel_i});
  endtask

  task automatic compare();
    if (reset_i) begin
      chk("rst_ready", 32'(ready_o), 0);
      chk("rst_v0", 32'(v0_o), 0);
      chk("rst_v1", 32'(v1_o), 0);
      chk("rst_data0", data0_o, 0);
      chk("rst_mask1", mask1_o, 0);
    end else begin
      chk("ready", 32'(ready_o), 32'((q0.size() < ELS) && (q1.size() < ELS)));
      chk("v0", 32'(v0_o), 32'(q0.size() > 0));
      chk("v1", 32'(v1_o), 32'(q1.size() > 0));
      if (q0.size() > 0) begin
        chk("data0", data0_o, q0[0][W-1:0]);
        chk("mask0", mask0_o, q0[0][2*W-1:W]);
      end
      if (q1.size() > 0) begin
        chk("data1", data1_o, q1[0][W-1:0]);
        chk("mask1", mask1_o, q1[0][2*W-1:W]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; data_i = '0; sel_i = '0; yumi0_i = 1'b0; yumi1_i = 1'b0;
    step(); step();
    chk("reset_nd_v0", 32'(nd_v0), 0);
    chk("reset_nd_ready", 32'(nd_ready), 0);
    reset_i = 1'b0;
    step();
    chk("ready_after_reset", 32'(ready_o), 1);
    chk("nd_ready_after_reset", 32'(nd_ready), 1);

    // drop-empty: all-ones select feeds only channel 1 unless empties are kept
    v_i = 1'b1; data_i = 32'h12345678; sel_i = 32'hFFFFFFFF;
    step();
    v_i = 1'b0;
    chk("drop_v0", 32'(v0_o), 0);
    chk("drop_v1", 32'(v1_o), 1);
    chk("drop_data1", data1_o, 32'h12345678);
    chk("drop_mask1", mask1_o, 32'hFFFFFFFF);
    chk("keep_v0", 32'(nd_v0), 1);
    chk("keep_data0", nd_data0, 32'h0);
    chk("keep_mask0", nd_mask0, 32'h0);
    chk("keep_data1", nd_data1, 32'h12345678);
    yumi1_i = 1'b1;
    step();
    yumi1_i = 1'b0;

    // basic split
    v_i = 1'b1; data_i = 32'hDEADBEEF; sel_i = 32'hFFFF0000;
    step();
    v_i = 1'b0;
    chk("split_v0", 32'(v0_o), 1);
    chk("split_v1", 32'(v1_o), 1);
    chk("split_data0", data0_o, 32'h0000BEEF);
    chk("split_mask0", mask0_o, 32'h0000FFFF);
    chk("split_data1", data1_o, 32'hDEAD0000);
    chk("split_mask1", mask1_o, 32'hFFFF0000);
    yumi0_i = 1'b1; yumi1_i = 1'b1;
    step();
    yumi0_i = 1'b0; yumi1_i = 1'b0;
    chk("drained_v0", 32'(v0_o), 0);
    chk("drained_v1", 32'(v1_o), 0);

    // backpressure on channel 1
    v_i = 1'b1; sel_i = 32'hFFFFFFFF; data_i = 32'hA1A1A1A1;
    step();
    data_i = 32'hA2A2A2A2;
    step();
    v_i = 1'b0;
    chk("bp_ready_low", 32'(ready_o), 0);
    chk("bp_head_first", data1_o, 32'hA1A1A1A1);
    step();
    chk("bp_ready_hold", 32'(ready_o), 0);
    yumi1_i = 1'b1;
    #1;
    chk("bp_no_comb_ready", 32'(ready_o), 0);
    step();
    yumi1_i = 1'b0;
    chk("bp_ready_back", 32'(ready_o), 1);
    chk("bp_head_second", data1_o, 32'hA2A2A2A2);
    yumi1_i = 1'b1;
    step();
    yumi1_i = 1'b0;
    chk("bp_empty", 32'(v1_o), 0);

    // illegal yumi on an empty channel must leave the pointers alone
    yumi0_i = 1'b1;
    step();
    yumi0_i = 1'b0;
    chk("illegal_v0", 32'(v0_o), 0);
    chk("illegal_ready", 32'(ready_o), 1);
    v_i = 1'b1; data_i = 32'h0F0F0F0F; sel_i = 32'h0;
    step();
    v_i = 1'b0;
    chk("after_illegal_v0", 32'(v0_o), 1);
    chk("after_illegal_data0", data0_o, 32'h0F0F0F0F);
    chk("after_illegal_mask0", mask0_o, 32'hFFFFFFFF);
    chk("after_illegal_v1", 32'(v1_o), 0);
    yumi0_i = 1'b1;
    step();
    yumi0_i = 1'b0;
    chk("after_illegal_empty", 32'(v0_o), 0);

    // reset with both channels full
    v_i = 1'b1; sel_i = 32'hFFFF0000;
    for (int i = 0; i < ELS; i++) begin
      data_i = $urandom;
      step();
    end
    v_i = 1'b0;
    chk("full_ready", 32'(ready_o), 0);
    reset_i = 1'b1;
    #1;
    chk("midrst_v0", 32'(v0_o), 0);
    chk("midrst_v1", 32'(v1_o), 0);
    chk("midrst_ready", 32'(ready_o), 0);
    step();
    reset_i = 1'b0;
    step();
    chk("postrst_ready", 32'(ready_o), 1);
    chk("postrst_v0", 32'(v0_o), 0);
    chk("postrst_v1", 32'(v1_o), 0);

    // random traffic with legal random drains
    for (int i = 0; i < 10000; i++) begin
      v_i    = 1'b1;
      data_i = $urandom;
      case ($urandom_range(0, 7))
        0:       sel_i = '0;
        1:       sel_i = '1;
        default: sel_i = $urandom;
      endcase
      yumi0_i = (q0.size() > 0) && ($urandom_range(0, 1) == 1);
      yumi1_i = (q1.size() > 0) && ($urandom_range(0, 1) == 1);
      step();
    end

    v_i = 1'b0;
    for (int i = 0; i < 2 * ELS + 2; i++) begin
      yumi0_i = (q0.size() > 0);
      yumi1_i = (q1.size() > 0);
      step();
    end
    yumi0_i = 1'b0; yumi1_i = 1'b0;
    chk("final_v0", 32'(v0_o), 0);
    chk("final_v1", 32'(v1_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
